// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver with a configurable data width, parity mode and
//   stop-bit count. The oversampling tick is divided down from clk. The
//   receiver rejects false starts and reports parity and framing/break errors.
//   Flags qualify data_out: data is delivered even when a flag is set.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9), LSB first
//   PARITY      0 = none, 1 = even, 2 = odd
//   STOP_BITS   1 or 2
//   CLK_DIV     clk cycles per oversample tick (>= 2)
//   OVERSAMPLE  ticks per bit period (even, >= 4)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   rx             serial input, idle high, asynchronous to clk
//   data_out       last received word, right-aligned
//   data_ready     1-clk pulse: frame complete, data_out and flags valid
//   parity_error   parity mismatch on last frame (always 0 when PARITY = 0)
//   framing_error  a stop bit was sampled low on last frame
//   busy           high in every state except IDLE
// ----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int CLK_DIV    = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TICK_HALF  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
    localparam logic          ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rxs_q, rxs_d;
    logic                   rxs_prev_q, rxs_prev_d;
    logic [DW-1:0]          div_cnt_q, div_cnt_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   perr_frame_q, perr_frame_d;
    logic                   ferr_frame_q, ferr_frame_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   data_ready_q, data_ready_d;
    logic                   parity_error_q, parity_error_d;
    logic                   framing_error_q, framing_error_d;
    logic                   tick;
    logic                   sample;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d         = state_q;
        rx_meta_d       = rx;
        rxs_d           = rx_meta_q;
        rxs_prev_d      = rxs_q;
        div_cnt_d       = div_cnt_q;
        tick_cnt_d      = tick_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shreg_d         = shreg_q;
        perr_frame_d    = perr_frame_q;
        ferr_frame_d    = ferr_frame_q;
        data_out_d      = data_out_q;
        data_ready_d    = 1'b0;
        parity_error_d  = parity_error_q;
        framing_error_d = framing_error_q;
        tick            = 1'b0;
        sample          = 1'b0;

        // Free-running divider; realigned to the start edge below.
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            tick      = 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        // START samples half a bit in; every later sample is one full bit
        // after the previous one, which keeps all samples at mid-bit.
        if (state_q != S_IDLE && tick) begin
            if (state_q == S_START) begin
                sample = (tick_cnt_q == TICK_HALF);
            end else begin
                sample = (tick_cnt_q == TICK_LAST);
            end
            tick_cnt_d = sample ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d    = S_START;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                end
            end
            S_START: begin
                if (sample) begin
                    if (!rxs_q) begin
                        state_d      = S_DATA;
                        bit_cnt_d    = '0;
                        perr_frame_d = 1'b0;
                        ferr_frame_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    // LSB arrives first, so shifting in at the top leaves the
                    // word right-aligned after DATA_BITS samples.
                    shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    perr_frame_d = (^shreg_q) ^ rxs_q ^ ODD_PARITY;
                    state_d      = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    ferr_frame_d = ferr_frame_q | ~rxs_q;
                    if (bit_cnt_q == STOP_LAST) begin
                        data_out_d      = shreg_q;
                        parity_error_d  = perr_frame_q;
                        framing_error_d = ferr_frame_q | ~rxs_q;
                        data_ready_d    = 1'b1;
                        // A low final stop bit means the line may be in
                        // break; hold off new starts until it returns high.
                        state_d         = rxs_q ? S_IDLE : S_BREAK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            rx_meta_q       <= 1'b1;
            rxs_q           <= 1'b1;
            rxs_prev_q      <= 1'b1;
            div_cnt_q       <= '0;
            tick_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            shreg_q         <= '0;
            perr_frame_q    <= 1'b0;
            ferr_frame_q    <= 1'b0;
            data_out_q      <= '0;
            data_ready_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rx_meta_q       <= rx_meta_d;
            rxs_q           <= rxs_d;
            rxs_prev_q      <= rxs_prev_d;
            div_cnt_q       <= div_cnt_d;
            tick_cnt_q      <= tick_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shreg_q         <= shreg_d;
            perr_frame_q    <= perr_frame_d;
            ferr_frame_q    <= ferr_frame_d;
            data_out_q      <= data_out_d;
            data_ready_q    <= data_ready_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
        end
    end

    assign data_out      = data_out_q;
    assign data_ready    = data_ready_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_param
//   Directed bench for uart_rx_param. Instance A: 8 data bits, even parity,
//   1 stop bit. Instance B: 7 data bits, odd parity, 2 stop bits. Both use
//   CLK_DIV = 4 and OVERSAMPLE = 16, i.e. 64 clk per bit. Expected words and
//   flags are queued as each frame is driven and popped on every data_ready.
// ----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int BIT = 64;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       dr_a, dr_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic       busy_a, busy_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   checks = 0;
    int   passed = 0;
    int   cnt_a  = 0;
    int   cnt_b  = 0;
    int   snap;

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLK_DIV(4), .OVERSAMPLE(16)
    ) dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .data_out(data_a),
        .data_ready(dr_a), .parity_error(perr_a), .framing_error(ferr_a),
        .busy(busy_a)
    );

    uart_rx_param #(
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLK_DIV(4), .OVERSAMPLE(16)
    ) dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .data_out(data_b),
        .data_ready(dr_b), .parity_error(perr_b), .framing_error(ferr_b),
        .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: every data_ready must match the oldest queued frame.
    always @(negedge clk) begin
        if (dr_a) begin
            cnt_a++;
            if (q_a.size() == 0) begin
                check("a_spurious_ready", 32'(dr_a), 32'd0);
            end else begin
                e_a = q_a.pop_front();
                check("a_data", 32'(data_a), 32'(e_a.data));
                check("a_parity_error", 32'(perr_a), 32'(e_a.perr));
                check("a_framing_error", 32'(ferr_a), 32'(e_a.ferr));
            end
        end
        if (dr_b) begin
            cnt_b++;
            if (q_b.size() == 0) begin
                check("b_spurious_ready", 32'(dr_b), 32'd0);
            end else begin
                e_b = q_b.pop_front();
                check("b_data", 32'(data_b), 32'(e_b.data));
                check("b_parity_error", 32'(perr_b), 32'(e_b.perr));
                check("b_framing_error", 32'(ferr_b), 32'(e_b.ferr));
            end
        end
    end

    task automatic drive_bit(input bit which, input logic v, input int clks);
        if (which) rx_b = v;
        else       rx_a = v;
        repeat (clks) @(negedge clk);
    endtask

    // Drives start, nbits data (LSB first), optional parity (flip_par inverts
    // it), then nstop stop bits at stop_val. The matching expectation is
    // queued before the first bit goes out.
    task automatic send_frame(input bit which, input logic [8:0] data, input int nbits,
                              input int pmode, input logic flip_par,
                              input int nstop, input logic stop_val);
        logic p;
        exp_t e;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ data[i];
        if (pmode == 2) p = ~p;
        e.data = data;
        e.perr = (pmode != 0) && flip_par;
        e.ferr = (nstop == 0) || !stop_val;
        if (which) q_b.push_back(e);
        else       q_a.push_back(e);
        drive_bit(which, 1'b0, BIT);
        for (int i = 0; i < nbits; i++) drive_bit(which, data[i], BIT);
        if (pmode != 0) drive_bit(which, p ^ flip_par, BIT);
        for (int s = 0; s < nstop; s++) drive_bit(which, stop_val, BIT);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(q_a.size() + q_b.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(data_a), 32'd0);
        check("rst_ready", 32'({dr_a, dr_b}), 32'd0);
        check("rst_flags", 32'({perr_a, ferr_a, perr_b, ferr_b}), 32'd0);
        check("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // 1: good even-parity frame
        send_frame(1'b0, 9'h0A5, 8, 1, 1'b0, 1, 1'b1);
        wait_drain("t1_drain");
        check("t1_busy_idle", 32'(busy_a), 32'd0);
        check("t1_one_ready", 32'(cnt_a), 32'd1);
        repeat (10) @(negedge clk);

        // 2: parity bit wrong -> data still delivered, flag set
        send_frame(1'b0, 9'h0A5, 8, 1, 1'b1, 1, 1'b1);
        wait_drain("t2_drain");
        check("t2_perr_held", 32'(perr_a), 32'd1);

        // 4: short glitch is a false start and leaves the flags alone
        snap = cnt_a;
        rx_a = 1'b0;
        repeat (20) @(negedge clk);
        rx_a = 1'b1;
        begin
            int n;
            n = 20;
            while (busy_a && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        check("t4_busy_low", 32'(busy_a), 32'd0);
        repeat (40) @(negedge clk);
        check("t4_no_ready", 32'(cnt_a - snap), 32'd0);
        check("t4_perr_kept", 32'(perr_a), 32'd1);
        check("t4_data_kept", 32'(data_a), 32'h0A5);

        // 2 (cont.): next good frame clears the parity flag
        send_frame(1'b0, 9'h05A, 8, 1, 1'b0, 1, 1'b1);
        wait_drain("t2b_drain");
        check("t2b_perr_cleared", 32'(perr_a), 32'd0);
        repeat (10) @(negedge clk);

        // 3: stop bit low, line held low 300 clk -> framing error, BREAK
        snap = cnt_a;
        send_frame(1'b0, 9'h033, 8, 1, 1'b0, 0, 1'b0);
        drive_bit(1'b0, 1'b0, 300);
        check("t3_drain", 32'(q_a.size()), 32'd0);
        check("t3_ferr", 32'(ferr_a), 32'd1);
        check("t3_busy_in_break", 32'(busy_a), 32'd1);
        drive_bit(1'b0, 1'b1, 6);
        check("t3_busy_released", 32'(busy_a), 32'd0);
        repeat (100) @(negedge clk);
        check("t3_single_ready", 32'(cnt_a - snap), 32'd1);

        // 5: reset mid-DATA, then a clean frame
        drive_bit(1'b0, 1'b0, BIT);
        drive_bit(1'b0, 1'b1, BIT);
        drive_bit(1'b0, 1'b0, 30);
        reset = 1'b1;
        rx_a  = 1'b1;
        #1;
        check("t5_async_busy", 32'(busy_a), 32'd0);
        repeat (2) @(negedge clk);
        check("t5_data_zero", 32'(data_a), 32'd0);
        check("t5_flags_zero", 32'({dr_a, perr_a, ferr_a}), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        snap = cnt_a;
        send_frame(1'b0, 9'h03C, 8, 1, 1'b0, 1, 1'b1);
        wait_drain("t5_drain");
        repeat (20) @(negedge clk);
        check("t5_one_ready", 32'(cnt_a - snap), 32'd1);

        // 6: 7 data bits, odd parity, 2 stop bits, back-to-back frames
        send_frame(1'b1, 9'h041, 7, 2, 1'b0, 2, 1'b1);
        send_frame(1'b1, 9'h07F, 7, 2, 1'b0, 2, 1'b1);
        wait_drain("t6_drain");
        repeat (20) @(negedge clk);
        check("t6_two_ready", 32'(cnt_b), 32'd2);
        check("t6_busy_idle", 32'(busy_b), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
